// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single 64-bit on-chip memory port between the instruction fetcher
// (IF, read-only) and the load/store unit (LSU, read/write).
//  - One access per cycle. The LSU normally wins, but after MAX_WAIT consecutive
//    cycles in which IF was waiting while the LSU was granted, IF is given the
//    next slot.
//  - Read responses are routed back to the issuing requester exactly RD_LAT
//    cycles after the grant. The routing is done by a small shift register.
//  - A branch redirect (if_flush) cancels every IF read still in flight.
//    Grants themselves are not held off by a flush.
// Configuration macro:
//  ARB_PERF_EN  when defined, saturating 32-bit grant/conflict event counters
//               are built; otherwise the perf_* outputs are tied to zero.

module mem_port_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    input  logic        if_flush,
    output logic        if_rvalid,
    output logic [63:0] if_rdata,

    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_be,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [63:0] lsu_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_be,
    input  logic [63:0] mem_rdata,

    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_lsu_grants,
    output logic [31:0] perf_conflicts
);

    typedef enum logic {
        LSU_PRIO = 1'b0,
        FORCE_IF = 1'b1
    } arbState_t;

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    arbState_t        state;
    logic [CNT_W-1:0] waitCnt;

    logic ifGntInt;
    logic lsuGntInt;
    logic waitInc;
    logic waitClear;

    // One entry per cycle: valid read, issued by LSU (else IF), killed by flush
    logic [RD_LAT-1:0] pipeValid;
    logic [RD_LAT-1:0] pipeLsu;
    logic [RD_LAT-1:0] pipeKilled;

    // The low address bits are dropped because the port is 8-byte granular
    logic unusedAddrBits;
    assign unusedAddrBits = ^{if_addr[2:0], lsu_addr[2:0]};

    // Grant selection: the current arbitration state picks who wins a conflict
    always_comb begin
        ifGntInt  = 1'b0;
        lsuGntInt = 1'b0;
        if (!reset) begin
            if (state == FORCE_IF) begin
                if (if_req) begin
                    ifGntInt = 1'b1;
                end else if (lsu_req) begin
                    lsuGntInt = 1'b1;
                end
            end else begin
                if (lsu_req) begin
                    lsuGntInt = 1'b1;
                end else if (if_req) begin
                    ifGntInt = 1'b1;
                end
            end
        end
    end

    assign if_gnt  = ifGntInt;
    assign lsu_gnt = lsuGntInt;

    // IF starves one more cycle whenever it asks and the LSU takes the port
    assign waitInc   = if_req & lsuGntInt;
    assign waitClear = ifGntInt | ~if_req;

    // Arbitration FSM together with the anti-starvation wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LSU_PRIO;
            waitCnt <= '0;
        end else begin
            if (waitClear) begin
                waitCnt <= '0;
            end else if (waitInc && (waitCnt != CNT_W'(MAX_WAIT))) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end

            case (state)
                LSU_PRIO: begin
                    if (waitInc && (waitCnt == WAIT_LAST)) begin
                        state <= FORCE_IF;
                    end
                end
                FORCE_IF: begin
                    if (ifGntInt || !if_req) begin
                        state <= LSU_PRIO;
                    end
                end
                default: begin
                    state <= LSU_PRIO;
                end
            endcase
        end
    end

    // Memory port mux: follows the granted requester, everything zero when idle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 64'h0;
        mem_be    = 8'h00;
        if (lsuGntInt) begin
            mem_en   = 1'b1;
            mem_we   = lsu_we;
            mem_addr = {lsu_addr[31:3], 3'b000};
            if (lsu_we) begin
                mem_wdata = lsu_wdata;
                mem_be    = lsu_be;
            end else begin
                mem_be    = 8'hFF;
            end
        end else if (ifGntInt) begin
            mem_en   = 1'b1;
            mem_addr = {if_addr[31:3], 3'b000};
            mem_be   = 8'hFF;
        end
    end

    // Read tracking shift register; a flush kills IF entries as they move along
    always_ff @(posedge clk) begin
        if (reset) begin
            pipeValid  <= '0;
            pipeLsu    <= '0;
            pipeKilled <= '0;
        end else begin
            pipeValid[0]  <= ifGntInt | (lsuGntInt & ~lsu_we);
            pipeLsu[0]    <= lsuGntInt;
            pipeKilled[0] <= ifGntInt & if_flush;
            for (int i = 1; i < RD_LAT; i++) begin
                pipeValid[i]  <= pipeValid[i-1];
                pipeLsu[i]    <= pipeLsu[i-1];
                pipeKilled[i] <= pipeKilled[i-1] |
                                 (if_flush & pipeValid[i-1] & ~pipeLsu[i-1]);
            end
        end
    end

    assign if_rvalid  = ~reset & pipeValid[RD_LAT-1] & ~pipeLsu[RD_LAT-1]
                        & ~pipeKilled[RD_LAT-1];
    assign lsu_rvalid = ~reset & pipeValid[RD_LAT-1] & pipeLsu[RD_LAT-1];

    // Read data is shared; only the rvalid strobes say whose it is
    assign if_rdata  = reset ? 64'h0 : mem_rdata;
    assign lsu_rdata = reset ? 64'h0 : mem_rdata;

`ifdef ARB_PERF_EN
    logic [31:0] ifGrantCnt;
    logic [31:0] lsuGrantCnt;
    logic [31:0] conflictCnt;

    // Saturating event counters for grants and request conflicts
    always_ff @(posedge clk) begin
        if (reset) begin
            ifGrantCnt  <= 32'h0;
            lsuGrantCnt <= 32'h0;
            conflictCnt <= 32'h0;
        end else begin
            if (ifGntInt && (ifGrantCnt != 32'hFFFF_FFFF)) begin
                ifGrantCnt <= ifGrantCnt + 32'h1;
            end
            if (lsuGntInt && (lsuGrantCnt != 32'hFFFF_FFFF)) begin
                lsuGrantCnt <= lsuGrantCnt + 32'h1;
            end
            if (if_req && lsu_req && (conflictCnt != 32'hFFFF_FFFF)) begin
                conflictCnt <= conflictCnt + 32'h1;
            end
        end
    end

    assign perf_if_grants  = ifGrantCnt;
    assign perf_lsu_grants = lsuGrantCnt;
    assign perf_conflicts  = conflictCnt;
`else
    assign perf_if_grants  = 32'h0;
    assign perf_lsu_grants = 32'h0;
    assign perf_conflicts  = 32'h0;
`endif

endmodule
